// File: rtl/instruction_decoder_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder_core_if
//  Description : Bundle for the instruction decoder. It carries the raw
//                instruction with its valid strobe, and the registered
//                decoded fields and control flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_decoder_core_if;

  // Instruction side
  logic        in_valid;
  logic [31:0] instruction;

  // Decoded side
  logic        out_valid;
  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [11:0] literal;
  logic [3:0]  alu_op;
  logic        is_immediate;
  logic        reg_write_enable;
  logic        is_float;
  logic        illegal;

  // Instruction source and decode consumer
  modport master (
    output in_valid,
    output instruction,
    input  out_valid,
    input  opcode,
    input  rd,
    input  rs,
    input  rt,
    input  literal,
    input  alu_op,
    input  is_immediate,
    input  reg_write_enable,
    input  is_float,
    input  illegal
  );

  // Decoder
  modport slave (
    input  in_valid,
    input  instruction,
    output out_valid,
    output opcode,
    output rd,
    output rs,
    output rt,
    output literal,
    output alu_op,
    output is_immediate,
    output reg_write_enable,
    output is_float,
    output illegal
  );

endinterface
`default_nettype wire

// File: rtl/instruction_decoder_core.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decoder_core
//  Description : Single-stage registered instruction decoder. Splits a
//                32-bit instruction into opcode/rd/rs/rt/literal fields and
//                derives ALU operation, immediate select, register write
//                enable, float flag and illegal flag. One-cycle latency,
//                one decode per cycle, outputs hold while in_valid is low.
//  Config      : DECODER_FLOAT_EN - when defined, opcodes 0x14-0x17 decode
//                as floating-point ops; otherwise they are illegal and
//                is_float is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder_core (
  input  wire                          clk,
  input  wire                          rst_n,
  instruction_decoder_core_if.slave    bus
);

  // --------------------------------------------------------------------------
  // ALU operation codes
  // --------------------------------------------------------------------------
  localparam logic [3:0] ALU_ADD      = 4'd0;
  localparam logic [3:0] ALU_SUB      = 4'd1;
  localparam logic [3:0] ALU_MUL      = 4'd2;
  localparam logic [3:0] ALU_DIV      = 4'd3;
  localparam logic [3:0] ALU_AND      = 4'd4;
  localparam logic [3:0] ALU_OR       = 4'd5;
  localparam logic [3:0] ALU_XOR      = 4'd6;
  localparam logic [3:0] ALU_NOT      = 4'd7;
  localparam logic [3:0] ALU_SHR      = 4'd8;
  localparam logic [3:0] ALU_SHL      = 4'd9;
  localparam logic [3:0] ALU_PASS_RS  = 4'd10;
  localparam logic [3:0] ALU_PASS_LIT = 4'd11;
`ifdef DECODER_FLOAT_EN
  localparam logic [3:0] ALU_FADD     = 4'd12;
  localparam logic [3:0] ALU_FSUB     = 4'd13;
  localparam logic [3:0] ALU_FMUL     = 4'd14;
  localparam logic [3:0] ALU_FDIV     = 4'd15;
`endif

  // --------------------------------------------------------------------------
  // Field extraction (applies to every opcode, legal or not)
  // --------------------------------------------------------------------------
  logic [4:0]  fld_opcode;
  logic [4:0]  fld_rd;
  logic [4:0]  fld_rs;
  logic [4:0]  fld_rt;
  logic [11:0] fld_literal;

  assign fld_opcode  = bus.instruction[31:27];
  assign fld_rd      = bus.instruction[26:22];
  assign fld_rs      = bus.instruction[21:17];
  assign fld_rt      = bus.instruction[16:12];
  assign fld_literal = bus.instruction[11:0];

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic [3:0] dec_alu_op;
  logic       dec_is_immediate;
  logic       dec_reg_write_enable;
  logic       dec_illegal;
`ifdef DECODER_FLOAT_EN
  logic       dec_is_float;
`endif

  // Opcode to control-flag lookup; anything unlisted is illegal with all flags clear
  always_comb begin
    dec_alu_op           = ALU_ADD;
    dec_is_immediate     = 1'b0;
    dec_reg_write_enable = 1'b0;
    dec_illegal          = 1'b0;
`ifdef DECODER_FLOAT_EN
    dec_is_float         = 1'b0;
`endif
    case (fld_opcode)
      // Logic and shift group, all write rd
      5'h00: begin dec_alu_op = ALU_AND; dec_reg_write_enable = 1'b1; end
      5'h01: begin dec_alu_op = ALU_OR;  dec_reg_write_enable = 1'b1; end
      5'h02: begin dec_alu_op = ALU_XOR; dec_reg_write_enable = 1'b1; end
      5'h03: begin dec_alu_op = ALU_NOT; dec_reg_write_enable = 1'b1; end
      5'h04: begin dec_alu_op = ALU_SHR; dec_reg_write_enable = 1'b1; end
      5'h05: begin
        dec_alu_op           = ALU_SHR;
        dec_is_immediate     = 1'b1;
        dec_reg_write_enable = 1'b1;
      end
      5'h06: begin dec_alu_op = ALU_SHL; dec_reg_write_enable = 1'b1; end
      5'h07: begin
        dec_alu_op           = ALU_SHL;
        dec_is_immediate     = 1'b1;
        dec_reg_write_enable = 1'b1;
      end
      // Branch/call/return/privileged: address add, no register write
      5'h08, 5'h09, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F: begin
        dec_alu_op = ALU_ADD;
      end
      5'h0A: begin
        dec_alu_op       = ALU_ADD;
        dec_is_immediate = 1'b1;
      end
      // Memory and move group
      5'h10: begin
        dec_alu_op           = ALU_ADD;
        dec_is_immediate     = 1'b1;
        dec_reg_write_enable = 1'b1;
      end
      5'h11: begin dec_alu_op = ALU_PASS_RS; dec_reg_write_enable = 1'b1; end
      5'h12: begin
        dec_alu_op           = ALU_PASS_LIT;
        dec_is_immediate     = 1'b1;
        dec_reg_write_enable = 1'b1;
      end
      5'h13: begin
        dec_alu_op       = ALU_ADD;
        dec_is_immediate = 1'b1;
      end
`ifdef DECODER_FLOAT_EN
      // Floating-point group
      5'h14: begin
        dec_alu_op = ALU_FADD; dec_is_float = 1'b1; dec_reg_write_enable = 1'b1;
      end
      5'h15: begin
        dec_alu_op = ALU_FSUB; dec_is_float = 1'b1; dec_reg_write_enable = 1'b1;
      end
      5'h16: begin
        dec_alu_op = ALU_FMUL; dec_is_float = 1'b1; dec_reg_write_enable = 1'b1;
      end
      5'h17: begin
        dec_alu_op = ALU_FDIV; dec_is_float = 1'b1; dec_reg_write_enable = 1'b1;
      end
`endif
      // Integer arithmetic group
      5'h18: begin dec_alu_op = ALU_ADD; dec_reg_write_enable = 1'b1; end
      5'h19: begin
        dec_alu_op           = ALU_ADD;
        dec_is_immediate     = 1'b1;
        dec_reg_write_enable = 1'b1;
      end
      5'h1A: begin dec_alu_op = ALU_SUB; dec_reg_write_enable = 1'b1; end
      5'h1B: begin
        dec_alu_op           = ALU_SUB;
        dec_is_immediate     = 1'b1;
        dec_reg_write_enable = 1'b1;
      end
      5'h1C: begin dec_alu_op = ALU_MUL; dec_reg_write_enable = 1'b1; end
      5'h1D: begin dec_alu_op = ALU_DIV; dec_reg_write_enable = 1'b1; end
      // 0x1E, 0x1F (and 0x14-0x17 without float support)
      default: begin
        dec_alu_op  = ALU_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic        out_valid_d,        out_valid_q;
  logic [4:0]  opcode_d,           opcode_q;
  logic [4:0]  rd_d,               rd_q;
  logic [4:0]  rs_d,               rs_q;
  logic [4:0]  rt_d,               rt_q;
  logic [11:0] literal_d,          literal_q;
  logic [3:0]  alu_op_d,           alu_op_q;
  logic        is_immediate_d,     is_immediate_q;
  logic        reg_write_enable_d, reg_write_enable_q;
  logic        illegal_d,          illegal_q;
`ifdef DECODER_FLOAT_EN
  logic        is_float_d,         is_float_q;
`endif

  // Capture a fresh decode on in_valid, otherwise hold; out_valid tracks in_valid
  always_comb begin
    out_valid_d        = bus.in_valid;
    opcode_d           = opcode_q;
    rd_d               = rd_q;
    rs_d               = rs_q;
    rt_d               = rt_q;
    literal_d          = literal_q;
    alu_op_d           = alu_op_q;
    is_immediate_d     = is_immediate_q;
    reg_write_enable_d = reg_write_enable_q;
    illegal_d          = illegal_q;
`ifdef DECODER_FLOAT_EN
    is_float_d         = is_float_q;
`endif
    if (bus.in_valid) begin
      opcode_d           = fld_opcode;
      rd_d               = fld_rd;
      rs_d               = fld_rs;
      rt_d               = fld_rt;
      literal_d          = fld_literal;
      alu_op_d           = dec_alu_op;
      is_immediate_d     = dec_is_immediate;
      reg_write_enable_d = dec_reg_write_enable;
      illegal_d          = dec_illegal;
`ifdef DECODER_FLOAT_EN
      is_float_d         = dec_is_float;
`endif
    end
  end

  // State register with asynchronous clear of every output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q        <= 1'b0;
      opcode_q           <= 5'd0;
      rd_q               <= 5'd0;
      rs_q               <= 5'd0;
      rt_q               <= 5'd0;
      literal_q          <= 12'd0;
      alu_op_q           <= 4'd0;
      is_immediate_q     <= 1'b0;
      reg_write_enable_q <= 1'b0;
      illegal_q          <= 1'b0;
`ifdef DECODER_FLOAT_EN
      is_float_q         <= 1'b0;
`endif
    end else begin
      out_valid_q        <= out_valid_d;
      opcode_q           <= opcode_d;
      rd_q               <= rd_d;
      rs_q               <= rs_d;
      rt_q               <= rt_d;
      literal_q          <= literal_d;
      alu_op_q           <= alu_op_d;
      is_immediate_q     <= is_immediate_d;
      reg_write_enable_q <= reg_write_enable_d;
      illegal_q          <= illegal_d;
`ifdef DECODER_FLOAT_EN
      is_float_q         <= is_float_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.out_valid        = out_valid_q;
  assign bus.opcode           = opcode_q;
  assign bus.rd               = rd_q;
  assign bus.rs               = rs_q;
  assign bus.rt               = rt_q;
  assign bus.literal          = literal_q;
  assign bus.alu_op           = alu_op_q;
  assign bus.is_immediate     = is_immediate_q;
  assign bus.reg_write_enable = reg_write_enable_q;
  assign bus.illegal          = illegal_q;
`ifdef DECODER_FLOAT_EN
  assign bus.is_float         = is_float_q;
`else
  assign bus.is_float         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decoder_core
//  Description : Directed self-checking bench for instruction_decoder_core.
//                Expected values are hand-derived from the opcode map.
//                Follows DECODER_FLOAT_EN for the float-opcode expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instruction_decoder_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  instruction_decoder_core_if bus ();

  instruction_decoder_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every decoder output
  task automatic chk_all(input string tag, input logic v, input logic [4:0] op,
                         input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [11:0] lit,
                         input logic [3:0] alu, input logic imm, input logic we,
                         input logic fl, input logic ill);
    chk({tag, ".out_valid"},        {31'd0, bus.out_valid},        {31'd0, v});
    chk({tag, ".opcode"},           {27'd0, bus.opcode},           {27'd0, op});
    chk({tag, ".rd"},               {27'd0, bus.rd},               {27'd0, rd});
    chk({tag, ".rs"},               {27'd0, bus.rs},               {27'd0, rs});
    chk({tag, ".rt"},               {27'd0, bus.rt},               {27'd0, rt});
    chk({tag, ".literal"},          {20'd0, bus.literal},          {20'd0, lit});
    chk({tag, ".alu_op"},           {28'd0, bus.alu_op},           {28'd0, alu});
    chk({tag, ".is_immediate"},     {31'd0, bus.is_immediate},     {31'd0, imm});
    chk({tag, ".reg_write_enable"}, {31'd0, bus.reg_write_enable}, {31'd0, we});
    chk({tag, ".is_float"},         {31'd0, bus.is_float},         {31'd0, fl});
    chk({tag, ".illegal"},          {31'd0, bus.illegal},          {31'd0, ill});
  endtask

  // Drive on the falling edge, return 1 ns after the capturing rising edge
  task automatic step(input logic v, input logic [31:0] instr);
    @(negedge clk);
    bus.in_valid    = v;
    bus.instruction = instr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [11:0] lit);
    return {op, rd, rs, rt, lit};
  endfunction

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.instruction = 32'h0;

    // Reset state, before and after clock edges with reset held
    #2;
    chk_all("reset_t2", 0, 5'h00, 0, 0, 0, 12'h000, 4'd0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 0, 5'h00, 0, 0, 0, 12'h000, 4'd0, 0, 0, 0, 0);

    // Release reset together with the first instruction: captured on that edge
    @(negedge clk);
    rst_n           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'hC044_3000;
    @(posedge clk);
    #1;
    chk_all("add", 1, 5'h18, 5'd1, 5'd2, 5'd3, 12'h000, 4'd0, 0, 1, 0, 0);

    // Back-to-back decodes, one per cycle
    step(1, 32'hC840_003F);
    chk_all("addi", 1, 5'h19, 5'd1, 5'd0, 5'd0, 12'h03F, 4'd0, 1, 1, 0, 0);

    step(1, 32'hA10A_6000);
`ifdef DECODER_FLOAT_EN
    chk_all("addf", 1, 5'h14, 5'd4, 5'd5, 5'd6, 12'h000, 4'd12, 0, 1, 1, 0);
`else
    chk_all("addf_off", 1, 5'h14, 5'd4, 5'd5, 5'd6, 12'h000, 4'd0, 0, 0, 0, 1);
`endif

    step(1, 32'hF800_0000);
    chk_all("illegal_1f", 1, 5'h1F, 5'd0, 5'd0, 5'd0, 12'h000, 4'd0, 0, 0, 0, 1);

    step(1, 32'h9800_0000);
    chk_all("store", 1, 5'h13, 5'd0, 5'd0, 5'd0, 12'h000, 4'd0, 1, 0, 0, 0);

    // in_valid low: only out_valid drops, decode held
    step(0, 32'hDEAD_BEEF);
    chk_all("store_hold", 0, 5'h13, 5'd0, 5'd0, 5'd0, 12'h000, 4'd0, 1, 0, 0, 0);

    step(1, mk(5'h05, 5'd7, 5'd8, 5'd9, 12'hABC));
    chk_all("shftri", 1, 5'h05, 5'd7, 5'd8, 5'd9, 12'hABC, 4'd8, 1, 1, 0, 0);

    step(1, mk(5'h0A, 5'd31, 5'd1, 5'd30, 12'h800));
    chk_all("branch_0a", 1, 5'h0A, 5'd31, 5'd1, 5'd30, 12'h800, 4'd0, 1, 0, 0, 0);

    step(1, mk(5'h0F, 5'd2, 5'd3, 5'd4, 12'h001));
    chk_all("priv_0f", 1, 5'h0F, 5'd2, 5'd3, 5'd4, 12'h001, 4'd0, 0, 0, 0, 0);

    step(1, mk(5'h12, 5'd10, 5'd11, 5'd12, 12'hFFF));
    chk_all("movlit", 1, 5'h12, 5'd10, 5'd11, 5'd12, 12'hFFF, 4'd11, 1, 1, 0, 0);

    step(1, mk(5'h11, 5'd13, 5'd14, 5'd15, 12'h123));
    chk_all("movreg", 1, 5'h11, 5'd13, 5'd14, 5'd15, 12'h123, 4'd10, 0, 1, 0, 0);

    step(1, mk(5'h03, 5'd16, 5'd17, 5'd18, 12'h456));
    chk_all("not", 1, 5'h03, 5'd16, 5'd17, 5'd18, 12'h456, 4'd7, 0, 1, 0, 0);

    step(1, mk(5'h1D, 5'd19, 5'd20, 5'd21, 12'h789));
    chk_all("div", 1, 5'h1D, 5'd19, 5'd20, 5'd21, 12'h789, 4'd3, 0, 1, 0, 0);

    step(1, mk(5'h1E, 5'd22, 5'd23, 5'd24, 12'h5A5));
    chk_all("illegal_1e", 1, 5'h1E, 5'd22, 5'd23, 5'd24, 12'h5A5, 4'd0, 0, 0, 0, 1);

    step(1, mk(5'h17, 5'd25, 5'd26, 5'd27, 12'h0F0));
`ifdef DECODER_FLOAT_EN
    chk_all("divf", 1, 5'h17, 5'd25, 5'd26, 5'd27, 12'h0F0, 4'd15, 0, 1, 1, 0);
`else
    chk_all("divf_off", 1, 5'h17, 5'd25, 5'd26, 5'd27, 12'h0F0, 4'd0, 0, 0, 0, 1);
`endif

    step(1, mk(5'h06, 5'd1, 5'd1, 5'd1, 12'h001));
    chk_all("shftl", 1, 5'h06, 5'd1, 5'd1, 5'd1, 12'h001, 4'd9, 0, 1, 0, 0);

    // Asynchronous reset pulsed between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 0, 5'h00, 0, 0, 0, 12'h000, 4'd0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.instruction = 32'hC840_003F;
    @(posedge clk);
    #1;
    chk_all("after_midrst", 1, 5'h19, 5'd1, 5'd0, 5'd0, 12'h03F, 4'd0, 1, 1, 0, 0);

    step(0, 32'h0000_0000);
    chk_all("final_idle", 0, 5'h19, 5'd1, 5'd0, 5'd0, 12'h03F, 4'd0, 1, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_decoder_core.md
INSTRUCTION_DECODER_CORE -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  instruction is valid and must be captured this cycle.
REQ-005 instruction  input  32  raw instruction word.
REQ-006 out_valid  output  1  decoded outputs are valid this cycle.
REQ-007 opcode  output  5  instruction[31:27].
REQ-008 rd  output  5  instruction[26:22].
REQ-009 rs  output  5  instruction[21:17].
REQ-010 rt  output  5  instruction[16:12].
REQ-011 literal  output  12  instruction[11:0], zero-extended by consumers.
REQ-012 alu_op  output  4  ALU operation code (REQ-017).
REQ-013 is_immediate  output  1  second operand is literal, not rt.
REQ-014 reg_write_enable  output  1  instruction writes rd.
REQ-015 is_float  output  1  floating-point instruction.
REQ-016 illegal  output  1  opcode unsupported.

Function
REQ-017 alu_op encoding SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHR, 9 SHL, 10 PASS_RS, 11 PASS_LIT, 12 FADD, 13 FSUB, 14 FMUL, 15 FDIV.
REQ-018 Opcode map SHALL be: 0x00 and(4), 0x01 or(5), 0x02 xor(6), 0x03 not(7), 0x04 shftr(8), 0x05 shftri(8,imm), 0x06 shftl(9), 0x07 shftli(9,imm), 0x08-0x0F branch/call/return/priv group (ADD, no write; 0x0A imm), 0x10 load(ADD,imm,write), 0x11 mov reg(10,write), 0x12 mov literal(11,imm,write), 0x13 store(ADD,imm,no write), 0x14-0x17 addf/subf/mulf/divf(12-15,float,write), 0x18 add(0,write), 0x19 addi(0,imm,write), 0x1A sub(1,write), 0x1B subi(1,imm,write), 0x1C mul(2,write), 0x1D div(3,write).
REQ-019 Write enable SHALL be 1 for opcodes 0x00-0x07, 0x10-0x12, 0x14-0x1D; 0 otherwise.
REQ-020 Opcodes 0x1E, 0x1F SHALL set illegal=1, alu_op=0, is_immediate=0, reg_write_enable=0, is_float=0.
REQ-021 Field outputs (opcode, rd, rs, rt, literal) SHALL be extracted for every opcode, legal or not.
REQ-022 All outputs SHALL be registered: on a rising clk edge with in_valid=1 they update from instruction; latency exactly one cycle.
REQ-023 out_valid SHALL equal in_valid delayed one cycle.
REQ-024 With in_valid=0, decoded outputs SHALL hold previous values; only out_valid drops.
REQ-025 Back-to-back in_valid every cycle SHALL yield one decode per cycle, no bubbles.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) clear every output to 0, including out_valid.
REQ-027 Reset release SHALL take effect at the next rising clk; an instruction presented on that edge is captured.

Configuration
REQ-028 Macro DECODER_FLOAT_EN: defined -> opcodes 0x14-0x17 decode per REQ-018; undefined -> they decode as illegal (REQ-020) and is_float is constant 0.

Verification
REQ-029 in_valid=1, instruction=0xC0443000 -> next cycle opcode=0x18, rd=1, rs=2, rt=3, literal=0, alu_op=0, is_immediate=0, reg_write_enable=1, is_float=0, illegal=0, out_valid=1.
REQ-030 instruction=0xC840003F -> opcode=0x19, rd=1, literal=0x03F, alu_op=0, is_immediate=1, reg_write_enable=1, is_float=0.
REQ-031 instruction=0xA10A6000 -> with DECODER_FLOAT_EN: opcode=0x14, rd=4, rs=5, rt=6, alu_op=12, is_float=1, reg_write_enable=1; without: illegal=1, reg_write_enable=0, is_float=0.
REQ-032 instruction=0xF8000000 -> illegal=1, alu_op=0, reg_write_enable=0, is_immediate=0.
REQ-033 Decode 0x98000000 (store, opcode 0x13) then in_valid=0 one cycle -> is_immediate=1, reg_write_enable=0 held, out_valid=1 then 0.
REQ-034 rst_n pulsed low mid-stream between clock edges -> all outputs 0 immediately; first decode after release correct after one cycle.
